// File: rtl/fifo_ram_ctrl.sv
// Single-clock FIFO over an inferable RAM with any depth, occupancy count, almost flags,
// sticky overflow/underflow and a choice of registered-read or first-word-fall-through output.
module fifo_ram_ctrl #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DATA_DEPTH   = 640,
    parameter int unsigned FWFT         = 0,
    parameter int unsigned AFULL_LEVEL  = 638,
    parameter int unsigned AEMPTY_LEVEL = 2,
    localparam int unsigned PTR_W       = $clog2(DATA_DEPTH),
    localparam int unsigned CNT_W       = $clog2(DATA_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    output logic                  wr_almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_empty,
    output logic                  rd_almost_empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_d;
    logic [CNT_W-1:0]      head_cnt;
    logic [CNT_W-1:0]      mem_cnt;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  mem_load;
    logic                  valid_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DATA_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign wr_acc = wr_en & ~wr_full;
    assign rd_acc = rd_en & ~rd_empty;

    // In FWFT mode the output register is part of count, so RAM holds count minus the head.
    assign head_cnt = (FWFT != 0) ? CNT_W'(rd_valid) : '0;
    assign mem_cnt  = count - head_cnt;

    always_comb begin
        count_d  = count;
        mem_load = rd_acc;
        valid_d  = rd_acc;
        if (wr_acc && !rd_acc) begin
            count_d = count + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count - CNT_W'(1);
        end
        if (FWFT != 0) begin
            mem_load = (mem_cnt != '0) && (!rd_valid || rd_acc);
            valid_d  = mem_load | (rd_valid & ~rd_acc);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            rd_data         <= '0;
            rd_valid        <= 1'b0;
            rd_empty        <= 1'b1;
            rd_almost_empty <= 1'b1;
            wr_full         <= 1'b0;
            wr_almost_full  <= 1'b0;
            overflow        <= 1'b0;
            underflow       <= 1'b0;
        end else if (clr) begin
            // rd_data deliberately holds across a flush
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            rd_valid        <= 1'b0;
            rd_empty        <= 1'b1;
            rd_almost_empty <= 1'b1;
            wr_full         <= 1'b0;
            wr_almost_full  <= 1'b0;
            overflow        <= 1'b0;
            underflow       <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (mem_load) begin
                rd_ptr  <= next_ptr(rd_ptr);
                rd_data <= mem[rd_ptr];
            end
            count           <= count_d;
            rd_valid        <= valid_d;
            rd_empty        <= (FWFT != 0) ? ~valid_d : (count_d == '0);
            rd_almost_empty <= count_d <= CNT_W'(AEMPTY_LEVEL);
            wr_full         <= count_d == CNT_W'(DATA_DEPTH);
            wr_almost_full  <= count_d >= CNT_W'(AFULL_LEVEL);
            overflow        <= overflow | (wr_en & wr_full);
            underflow       <= underflow | (rd_en & rd_empty);
        end
    end

    // Storage is never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc && !clr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Bench for fifo_ram_ctrl: three instances (depth 5 registered, depth 640 registered,
// depth 5 FWFT) with a scoreboard queue per instance checking data order.
module tb_fifo_ram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int b_pops  = 0;
    int c_pops  = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] q_c[$];

    logic       rst_a, clr_a, wr_en_a, rd_en_a;
    logic [7:0] wr_data_a, rd_data_a;
    logic       wr_full_a, wr_almost_full_a, rd_valid_a, rd_empty_a, rd_almost_empty_a;
    logic       overflow_a, underflow_a;
    logic [2:0] count_a;

    logic       rst_b, clr_b, wr_en_b, rd_en_b;
    logic [7:0] wr_data_b, rd_data_b;
    logic       wr_full_b, wr_almost_full_b, rd_valid_b, rd_empty_b, rd_almost_empty_b;
    logic       overflow_b, underflow_b;
    logic [9:0] count_b;

    logic       rst_c, clr_c, wr_en_c, rd_en_c;
    logic [7:0] wr_data_c, rd_data_c;
    logic       wr_full_c, wr_almost_full_c, rd_valid_c, rd_empty_c, rd_almost_empty_c;
    logic       overflow_c, underflow_c;
    logic [2:0] count_c;

    fifo_ram_ctrl #(
        .DATA_WIDTH(8), .DATA_DEPTH(5), .FWFT(0), .AFULL_LEVEL(4), .AEMPTY_LEVEL(1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_a), .clr(clr_a), .wr_en(wr_en_a), .wr_data(wr_data_a),
        .wr_full(wr_full_a), .wr_almost_full(wr_almost_full_a), .rd_en(rd_en_a),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_empty(rd_empty_a),
        .rd_almost_empty(rd_almost_empty_a), .count(count_a), .overflow(overflow_a),
        .underflow(underflow_a)
    );

    fifo_ram_ctrl #(
        .DATA_WIDTH(8), .DATA_DEPTH(640), .FWFT(0), .AFULL_LEVEL(638), .AEMPTY_LEVEL(2)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_b), .clr(clr_b), .wr_en(wr_en_b), .wr_data(wr_data_b),
        .wr_full(wr_full_b), .wr_almost_full(wr_almost_full_b), .rd_en(rd_en_b),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_empty(rd_empty_b),
        .rd_almost_empty(rd_almost_empty_b), .count(count_b), .overflow(overflow_b),
        .underflow(underflow_b)
    );

    fifo_ram_ctrl #(
        .DATA_WIDTH(8), .DATA_DEPTH(5), .FWFT(1), .AFULL_LEVEL(4), .AEMPTY_LEVEL(1)
    ) u_dut_c (
        .clk(clk), .rst_n(rst_c), .clr(clr_c), .wr_en(wr_en_c), .wr_data(wr_data_c),
        .wr_full(wr_full_c), .wr_almost_full(wr_almost_full_c), .rd_en(rd_en_c),
        .rd_data(rd_data_c), .rd_valid(rd_valid_c), .rd_empty(rd_empty_c),
        .rd_almost_empty(rd_almost_empty_c), .count(count_c), .overflow(overflow_c),
        .underflow(underflow_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Registered-read instances deliver one word per rd_valid cycle.
    always @(negedge clk) begin
        if (rd_valid_a) begin
            if (q_a.size() == 0) check("a_sb_underrun", 32'(rd_valid_a), 32'd0);
            else check("a_sb_data", 32'(rd_data_a), 32'(q_a.pop_front()));
        end
        if (rd_valid_b) begin
            b_pops++;
            if (q_b.size() == 0) check("b_sb_underrun", 32'(rd_valid_b), 32'd0);
            else check("b_sb_data", 32'(rd_data_b), 32'(q_b.pop_front()));
        end
        // FWFT: the head word is consumed when rd_en meets rd_valid.
        if (rd_valid_c && rd_en_c) begin
            c_pops++;
            if (q_c.size() == 0) check("c_sb_underrun", 32'(rd_valid_c), 32'd0);
            else check("c_sb_data", 32'(rd_data_c), 32'(q_c.pop_front()));
        end
    end

    task automatic check_reset_a(input string t);
        check({t, "_count"}, 32'(count_a), 32'd0);
        check({t, "_rd_data"}, 32'(rd_data_a), 32'd0);
        check({t, "_rd_valid"}, 32'(rd_valid_a), 32'd0);
        check({t, "_rd_empty"}, 32'(rd_empty_a), 32'd1);
        check({t, "_aempty"}, 32'(rd_almost_empty_a), 32'd1);
        check({t, "_full"}, 32'(wr_full_a), 32'd0);
        check({t, "_afull"}, 32'(wr_almost_full_a), 32'd0);
        check({t, "_overflow"}, 32'(overflow_a), 32'd0);
        check({t, "_underflow"}, 32'(underflow_a), 32'd0);
    endtask

    task automatic run_a();
        logic [7:0] d;
        for (int i = 0; i < 5; i++) begin
            d = 8'(8'h11 + i);
            wr_en_a = 1'b1; wr_data_a = d; q_a.push_back(d);
            tick();
            check("a_fill_count", 32'(count_a), 32'(i + 1));
            check("a_fill_afull", 32'(wr_almost_full_a), 32'(i + 1 >= 4));
            check("a_fill_aempty", 32'(rd_almost_empty_a), 32'(i + 1 <= 1));
        end
        check("a_full", 32'(wr_full_a), 32'd1);
        wr_data_a = 8'h99;
        tick();
        wr_en_a = 1'b0;
        check("a_overflow", 32'(overflow_a), 32'd1);
        check("a_ovf_count", 32'(count_a), 32'd5);
        for (int i = 0; i < 5; i++) begin
            rd_en_a = 1'b1;
            tick();
            check("a_rd_valid", 32'(rd_valid_a), 32'd1);
            check("a_rd_count", 32'(count_a), 32'(4 - i));
            check("a_rd_aempty", 32'(rd_almost_empty_a), 32'(4 - i <= 1));
        end
        tick();
        rd_en_a = 1'b0;
        check("a_underflow", 32'(underflow_a), 32'd1);
        check("a_udf_valid", 32'(rd_valid_a), 32'd0);
        check("a_udf_hold", 32'(rd_data_a), 32'h15);
        check("a_udf_empty", 32'(rd_empty_a), 32'd1);
        // Simultaneous write and read at count 1.
        wr_en_a = 1'b1; wr_data_a = 8'h60; q_a.push_back(8'h60);
        tick();
        wr_data_a = 8'h61; q_a.push_back(8'h61); rd_en_a = 1'b1;
        tick();
        check("a_wr_rd_count", 32'(count_a), 32'd1);
        wr_en_a = 1'b0;
        tick();
        rd_en_a = 1'b0;
        check("a_wr_rd_drain", 32'(count_a), 32'd0);
        // Flush at count 3 with write and read also requested.
        for (int i = 0; i < 3; i++) begin
            d = 8'(8'h31 + i);
            wr_en_a = 1'b1; wr_data_a = d; q_a.push_back(d);
            tick();
        end
        check("a_pre_clr_count", 32'(count_a), 32'd3);
        clr_a = 1'b1; wr_data_a = 8'h77; rd_en_a = 1'b1;
        tick();
        clr_a = 1'b0; wr_en_a = 1'b0; rd_en_a = 1'b0;
        q_a.delete();
        check("a_clr_count", 32'(count_a), 32'd0);
        check("a_clr_empty", 32'(rd_empty_a), 32'd1);
        check("a_clr_overflow", 32'(overflow_a), 32'd0);
        check("a_clr_underflow", 32'(underflow_a), 32'd0);
        check("a_clr_valid", 32'(rd_valid_a), 32'd0);
        check("a_clr_hold", 32'(rd_data_a), 32'h61);
        wr_en_a = 1'b1; wr_data_a = 8'h42; q_a.push_back(8'h42);
        tick();
        wr_en_a = 1'b0; rd_en_a = 1'b1;
        tick();
        rd_en_a = 1'b0;
        // Asynchronous reset in the middle of a transfer.
        wr_en_a = 1'b1; wr_data_a = 8'h50; q_a.push_back(8'h50);
        tick();
        wr_data_a = 8'h51; q_a.push_back(8'h51); rd_en_a = 1'b1;
        tick();
        wr_data_a = 8'h52;
        #6;
        rst_a = 1'b0;
        #1;
        q_a.delete();
        check_reset_a("a_midrst");
        wr_en_a = 1'b0; rd_en_a = 1'b0;
        tick();
        rst_a = 1'b1;
        tick();
        wr_en_a = 1'b1; wr_data_a = 8'h5a; q_a.push_back(8'h5a);
        tick();
        wr_en_a = 1'b0; rd_en_a = 1'b1;
        tick();
        rd_en_a = 1'b0;
        tick();
        check("a_post_rst_count", 32'(count_a), 32'd0);
    endtask

    task automatic run_b();
        for (int i = 0; i < 640; i++) begin
            wr_en_b = 1'b1; wr_data_b = 8'(i); q_b.push_back(8'(i));
            tick();
            if (i == 636) check("b_afull_below", 32'(wr_almost_full_b), 32'd0);
            if (i == 637) check("b_afull_at", 32'(wr_almost_full_b), 32'd1);
            if (i == 638) check("b_not_full", 32'(wr_full_b), 32'd0);
        end
        wr_en_b = 1'b0;
        check("b_full", 32'(wr_full_b), 32'd1);
        check("b_full_count", 32'(count_b), 32'd640);
        rd_en_b = 1'b1;
        tick();
        check("b_full_clear", 32'(wr_full_b), 32'd0);
        check("b_count_639", 32'(count_b), 32'd639);
        for (int i = 640; i < 2000; i++) begin
            wr_en_b = 1'b1; wr_data_b = 8'(i); q_b.push_back(8'(i));
            tick();
        end
        wr_en_b = 1'b0;
        check("b_stream_count", 32'(count_b), 32'd639);
        repeat (639) tick();
        rd_en_b = 1'b0;
        tick();
        tick();
        check("b_pops", 32'(b_pops), 32'd2000);
        check("b_end_count", 32'(count_b), 32'd0);
        check("b_end_empty", 32'(rd_empty_b), 32'd1);
        check("b_no_overflow", 32'(overflow_b), 32'd0);
        check("b_no_underflow", 32'(underflow_b), 32'd0);
    endtask

    task automatic run_c();
        logic [7:0] d;
        check("c_rst_valid", 32'(rd_valid_c), 32'd0);
        check("c_rst_empty", 32'(rd_empty_c), 32'd1);
        wr_en_c = 1'b1; wr_data_c = 8'ha5; q_c.push_back(8'ha5);
        tick();
        wr_en_c = 1'b0;
        check("c_wr_count", 32'(count_c), 32'd1);
        check("c_prefetch_valid", 32'(rd_valid_c), 32'd0);
        tick();
        check("c_fwft_valid", 32'(rd_valid_c), 32'd1);
        check("c_fwft_data", 32'(rd_data_c), 32'ha5);
        check("c_fwft_empty", 32'(rd_empty_c), 32'd0);
        rd_en_c = 1'b1;
        tick();
        rd_en_c = 1'b0;
        check("c_pop_count", 32'(count_c), 32'd0);
        check("c_pop_valid", 32'(rd_valid_c), 32'd0);
        for (int i = 0; i < 5; i++) begin
            d = 8'(8'hc0 + i);
            wr_en_c = 1'b1; wr_data_c = d; q_c.push_back(d);
            tick();
        end
        wr_en_c = 1'b0;
        check("c_full", 32'(wr_full_c), 32'd1);
        check("c_full_count", 32'(count_c), 32'd5);
        c_pops = 0;
        rd_en_c = 1'b1;
        repeat (5) tick();
        rd_en_c = 1'b0;
        check("c_b2b_pops", 32'(c_pops), 32'd5);
        check("c_b2b_count", 32'(count_c), 32'd0);
        check("c_b2b_no_udf", 32'(underflow_c), 32'd0);
        rd_en_c = 1'b1;
        tick();
        rd_en_c = 1'b0;
        check("c_underflow", 32'(underflow_c), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "timeout");
    end

    initial begin
        rst_a = 1'b0; clr_a = 1'b0; wr_en_a = 1'b0; rd_en_a = 1'b0; wr_data_a = '0;
        rst_b = 1'b0; clr_b = 1'b0; wr_en_b = 1'b0; rd_en_b = 1'b0; wr_data_b = '0;
        rst_c = 1'b0; clr_c = 1'b0; wr_en_c = 1'b0; rd_en_c = 1'b0; wr_data_c = '0;
        repeat (2) tick();
        check_reset_a("a_rst");
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        tick();
        run_a();
        run_b();
        run_c();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
